// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, 3-sample majority vote, FWFT receive FIFO, sticky errors.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  input  logic                          err_clr
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int B_W   = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  logic                 meta_q, sync_q;
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [B_W-1:0]       bidx_q, bidx_d;
  logic                 bad_q, bad_d;
  logic                 push_q, push_d;
  logic                 v0_q, v0_d, v1_q, v1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic tick, at_v0, at_v1, at_dec, bit_end, voted;
  logic set_fe, set_ov, pop, push_ok;

  always_comb begin
    tick    = (div_q == DIV_W'(DIV - 1));
    at_v0   = tick && (s_q == S_W'(OVERSAMPLE/2 - 1));
    at_v1   = tick && (s_q == S_W'(OVERSAMPLE/2));
    at_dec  = tick && (s_q == S_W'(OVERSAMPLE/2 + 1));
    bit_end = tick && (s_q == S_W'(OVERSAMPLE - 1));
    voted   = (v0_q & v1_q) | (v0_q & sync_q) | (v1_q & sync_q);
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q, parity_err_d, set_pe;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    s_d     = s_q;
    if (tick) s_d = (s_q == S_W'(OVERSAMPLE - 1)) ? '0 : s_q + 1'b1;
    bidx_d  = bidx_q;
    bad_d   = bad_q;
    push_d  = 1'b0;
    v0_d    = at_v0 ? sync_q : v0_q;
    v1_d    = at_v1 ? sync_q : v1_q;
    shreg_d = shreg_q;
    set_fe  = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_pe  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Realign the bit timebase to the detected start edge
        if (!sync_q) begin
          state_d = ST_START;
          div_d   = '0;
          s_d     = '0;
          bidx_d  = '0;
          bad_d   = 1'b0;
        end
      end
      ST_START: begin
        if (at_dec && voted) state_d = ST_IDLE;
        else if (bit_end)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_dec) shreg_d = {voted, shreg_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bidx_q == B_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (at_dec && (voted != ^shreg_q)) begin
          set_pe = 1'b1;
          bad_d  = 1'b1;
        end
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leave at the decision point so a start bit right after the stop bit is caught
        if (at_dec) begin
          if (!voted) begin
            set_fe  = 1'b1;
            state_d = ST_BREAK;
          end else begin
            push_d  = !bad_q;
            state_d = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop      = rx_valid & rx_ready;
    push_ok  = push_q & ((count_q != (AW+1)'(FIFO_DEPTH)) | pop);
    set_ov   = push_q & ~push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    frame_err_d = set_fe | (frame_err_q & ~err_clr);
    overrun_d   = set_ov | (overrun_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
    parity_err_d = set_pe | (parity_err_q & ~err_clr);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q      <= 1'b1;
      sync_q      <= 1'b1;
      state_q     <= ST_IDLE;
      div_q       <= '0;
      s_q         <= '0;
      bidx_q      <= '0;
      bad_q       <= 1'b0;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      meta_q      <= rxd;
      sync_q      <= meta_q;
      state_q     <= state_d;
      div_q       <= div_d;
      s_q         <= s_d;
      bidx_q      <= bidx_d;
      bad_q       <= bad_d;
      push_q      <= push_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    v0_q    <= v0_d;
    v1_q    <= v1_d;
    shreg_q <= shreg_d;
    if (push_ok) mem[wr_ptr_q] <= shreg_q;
  end

  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
